// File: rtl/multimode_reg_seq.sv
// multimode_reg_seq: WIDTH-bit sequenced register with eight operations.
// Repeatable ops run CNT times behind a START/BUSY/DONE handshake.
//
// Ports:
//   CLK, RESETN         clock, synchronous active-low reset
//   START, OP, D, CNT   request and its operands, latched on accept in IDLE
//   SER_IN              serial fill bit for shifts, sampled every RUN edge
//   Q, Q_BAR            register value and its registered complement
//   BUSY, DONE          high in RUN; one-cycle pulse after the last application
//   ABORT, ABORTED      only with MULTIMODE_REG_ABORT_EN defined: stop a RUN
//                       early; ABORTED flags the DONE pulse that results
module multimode_reg_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] D,
    input  logic [CW-1:0]    CNT,
    input  logic             SER_IN,
`ifdef MULTIMODE_REG_ABORT_EN
    input  logic             ABORT,
    output logic             ABORTED,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_BAR,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INV  = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROTL = 3'b110;
    localparam logic [2:0] OP_ROTR = 3'b111;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q;
    logic             abt_q, abt_d;
    logic             abort_w;
    logic             rpt;
    logic [WIDTH-1:0] applied;

`ifdef MULTIMODE_REG_ABORT_EN
    assign abort_w = ABORT;
    assign ABORTED = abt_q;
`else
    assign abort_w = 1'b0;
`endif

    // INVERT and every shift/rotate honour CNT; the rest apply once.
    assign rpt = OP[2] | (OP == OP_INV);

    always_comb begin
        applied = q_q;
        unique case (op_q)
            OP_HOLD: applied = q_q;
            OP_LOAD: applied = dat_q;
            OP_INV:  applied = ~q_q;
            OP_CLR:  applied = '0;
            OP_SHL:  applied = {q_q[WIDTH-2:0], SER_IN};
            OP_SHR:  applied = {SER_IN, q_q[WIDTH-1:1]};
            OP_ROTL: applied = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            OP_ROTR: applied = {q_q[0], q_q[WIDTH-1:1]};
            default: applied = q_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dat_d   = dat_q;
        rem_d   = rem_q;
        q_d     = q_q;
        abt_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d  = OP;
                    dat_d = D;
                    rem_d = rpt ? CNT : CW'(1);
                    // A zero-count repeatable op completes without touching Q.
                    if (rpt && (CNT == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort_w) begin
                    state_d = S_DONE;
                    abt_d   = 1'b1;
                end else begin
                    q_d = applied;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                    if (rem_q <= CW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            dat_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            qb_q    <= '1;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dat_q   <= dat_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            qb_q    <= ~q_d;
            abt_q   <= abt_d;
        end
    end

    assign Q     = q_q;
    assign Q_BAR = qb_q;
    assign BUSY  = (state_q == S_RUN);
    assign DONE  = (state_q == S_DONE);

endmodule

// File: tb/tb_multimode_reg_seq.sv
// tb_multimode_reg_seq: directed test of multimode_reg_seq (WIDTH=8, CW=4).
// Define MULTIMODE_REG_ABORT_EN to include the abort scenario.
module tb_multimode_reg_seq;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       START;
    logic [2:0] OP;
    logic [7:0] D;
    logic [3:0] CNT;
    logic       SER_IN;
    logic [7:0] Q;
    logic [7:0] Q_BAR;
    logic       BUSY;
    logic       DONE;
`ifdef MULTIMODE_REG_ABORT_EN
    logic       ABORT;
    logic       ABORTED;
`endif

    int checks = 0;
    int failures = 0;
    int pulses;

    always #5 CLK = ~CLK;

    multimode_reg_seq #(.WIDTH(8), .CW(4)) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .START(START),
        .OP(OP),
        .D(D),
        .CNT(CNT),
        .SER_IN(SER_IN),
`ifdef MULTIMODE_REG_ABORT_EN
        .ABORT(ABORT),
        .ABORTED(ABORTED),
`endif
        .Q(Q),
        .Q_BAR(Q_BAR),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and checks happen 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic accept(input logic [2:0] op, input logic [7:0] d,
                          input logic [3:0] cnt);
        OP = op;
        D = d;
        CNT = cnt;
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while (DONE !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk(tag, {31'd0, DONE}, 32'd1);
        step();
    endtask

    task automatic load(input logic [7:0] d);
        accept(3'b001, d, 4'd0);
        wait_done("load_done", 4);
    endtask

    initial begin
        RESETN = 1'b0;
        START = 1'b0;
        OP = '0;
        D = '0;
        CNT = '0;
        SER_IN = 1'b0;
`ifdef MULTIMODE_REG_ABORT_EN
        ABORT = 1'b0;
`endif
        step();
        step();
        chk("rst_q", 32'(Q), 32'h00);
        chk("rst_qb", 32'(Q_BAR), 32'hFF);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        RESETN = 1'b1;
        step();

        // LOAD ignores CNT: one RUN cycle, DONE two cycles after accept
        accept(3'b001, 8'hA5, 4'd7);
        chk("ld_busy", 32'(BUSY), 32'd1);
        chk("ld_q_early", 32'(Q), 32'h00);
        step();
        chk("ld_q", 32'(Q), 32'hA5);
        chk("ld_qb", 32'(Q_BAR), 32'h5A);
        chk("ld_done", 32'(DONE), 32'd1);
        chk("ld_busy2", 32'(BUSY), 32'd0);
        step();
        chk("ld_done_off", 32'(DONE), 32'd0);

        // reset after activity
        RESETN = 1'b0;
        step();
        chk("rst2_q", 32'(Q), 32'h00);
        chk("rst2_qb", 32'(Q_BAR), 32'hFF);
        chk("rst2_done", 32'(DONE), 32'd0);
        RESETN = 1'b1;
        step();

        // ROTL x3 from 81
        load(8'h81);
        chk("rl_pre", 32'(Q), 32'h81);
        accept(3'b110, 8'h00, 4'd3);
        chk("rl_busy0", 32'(BUSY), 32'd1);
        step();
        chk("rl_q1", 32'(Q), 32'h03);
        chk("rl_busy1", 32'(BUSY), 32'd1);
        step();
        chk("rl_q2", 32'(Q), 32'h06);
        chk("rl_busy2", 32'(BUSY), 32'd1);
        step();
        chk("rl_q3", 32'(Q), 32'h0C);
        chk("rl_qb3", 32'(Q_BAR), 32'hF3);
        chk("rl_busy3", 32'(BUSY), 32'd0);
        chk("rl_done", 32'(DONE), 32'd1);
        step();
        chk("rl_done_off", 32'(DONE), 32'd0);

        // ROTL x11 wraps to a net rotate by 3
        load(8'h81);
        accept(3'b110, 8'h00, 4'd11);
        wait_done("rl11_done", 14);
        chk("rl11_q", 32'(Q), 32'h0C);

        // SHR x4 from F0 with live serial fill 1,0,1,0
        load(8'hF0);
        accept(3'b101, 8'h00, 4'd4);
        SER_IN = 1'b1;
        step();
        chk("shr_q1", 32'(Q), 32'hF8);
        SER_IN = 1'b0;
        step();
        chk("shr_q2", 32'(Q), 32'h7C);
        SER_IN = 1'b1;
        step();
        chk("shr_q3", 32'(Q), 32'hBE);
        SER_IN = 1'b0;
        step();
        chk("shr_q4", 32'(Q), 32'h5F);
        chk("shr_done", 32'(DONE), 32'd1);
        step();

        // INVERT with CNT=0 goes straight to DONE
        accept(3'b010, 8'h00, 4'd0);
        chk("inv0_done", 32'(DONE), 32'd1);
        chk("inv0_busy", 32'(BUSY), 32'd0);
        chk("inv0_q", 32'(Q), 32'h5F);
        step();
        chk("inv0_idle", 32'(DONE), 32'd0);
        chk("inv0_q2", 32'(Q), 32'h5F);

        // INVERT x3 = one net inversion
        accept(3'b010, 8'h00, 4'd3);
        wait_done("inv3_done", 6);
        chk("inv3_q", 32'(Q), 32'hA0);

        // START held throughout SHL x5; operand changes mid-run ignored
        load(8'h01);
        SER_IN = 1'b0;
        OP = 3'b100;
        D = 8'h00;
        CNT = 4'd5;
        START = 1'b1;
        step();
        OP = 3'b001;
        D = 8'h77;
        CNT = 4'd1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            chk("shl_busy", 32'(BUSY), 32'd1);
            step();
        end
        chk("shl_q", 32'(Q), 32'h20);
        chk("shl_done", 32'(DONE), 32'd1);
        pulses += int'(DONE);
        step();
        chk("shl_idle_busy", 32'(BUSY), 32'd0);
        chk("shl_idle_done", 32'(DONE), 32'd0);
        chk("shl_idle_q", 32'(Q), 32'h20);
        chk("shl_pulses", 32'(pulses), 32'd1);
        step();
        START = 1'b0;
        chk("reacc_busy", 32'(BUSY), 32'd1);
        step();
        chk("reacc_q", 32'(Q), 32'h77);
        chk("reacc_done", 32'(DONE), 32'd1);
        step();

        // reset in the middle of ROTL x9: no DONE pulse
        load(8'h81);
        accept(3'b110, 8'h00, 4'd9);
        step();
        step();
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
        chk("rrun_q", 32'(Q), 32'h00);
        chk("rrun_qb", 32'(Q_BAR), 32'hFF);
        chk("rrun_busy", 32'(BUSY), 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            pulses += int'(DONE);
            step();
        end
        chk("rrun_nodone", 32'(pulses), 32'd0);

`ifdef MULTIMODE_REG_ABORT_EN
        // ROTR x8 from 01, abort on the third RUN edge
        load(8'h01);
        accept(3'b111, 8'h00, 4'd8);
        step();
        chk("ab_q1", 32'(Q), 32'h80);
        step();
        chk("ab_q2", 32'(Q), 32'h40);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("ab_q", 32'(Q), 32'h40);
        chk("ab_done", 32'(DONE), 32'd1);
        chk("ab_flag", 32'(ABORTED), 32'd1);
        chk("ab_busy", 32'(BUSY), 32'd0);
        step();
        chk("ab_done_off", 32'(DONE), 32'd0);
        chk("ab_flag_off", 32'(ABORTED), 32'd0);
        // ABORT while idle does nothing
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("ab_idle_done", 32'(DONE), 32'd0);
        chk("ab_idle_flag", 32'(ABORTED), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multimode_reg_seq.md
Name: multimode_reg_seq

Overview:
- Parametrised successor to the 8-bit hold/load/invert/clear register used on the lab boards.
- Generalised to WIDTH bits, with eight operations including shifts and rotates.
- Repeatable operations run CNT times under a small FSM with a START/BUSY/DONE handshake.
- Sits between the switch/key front end and the LED outputs, or any datapath needing a sequenced register.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CW, 4, width of the repeat-count input; max repeat = 2^CW-1.

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  synchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- OP  input  3  operation code, latched on accept.
- D  input  WIDTH  parallel load data, latched on accept.
- CNT  input  CW  repeat count, latched on accept.
- SER_IN  input  1  serial fill bit for shifts; sampled live every application cycle.
- Q  output  WIDTH  register value.
- Q_BAR  output  WIDTH  registered complement; always equals ~Q.
- BUSY  output  1  high in RUN.
- DONE  output  1  one-cycle pulse after the last application.

Behaviour:
- Clocking and reset: one clock, CLK. RESETN is synchronous and active-low, sampled on the CLK rising edge.
- Reset values (RESETN=0 at an edge): Q=0, Q_BAR=all ones, BUSY=0, DONE=0, state=IDLE, internal op/count/data cleared.
- Reset mid-RUN: operation abandoned with no DONE pulse; Q cleared.
- Opcodes:
  - 000 HOLD
  - 001 LOAD (Q<=D_latched)
  - 010 INVERT (Q<=~Q)
  - 011 CLEAR (Q<=0)
  - 100 SHL (Q<={Q[W-2:0],SER_IN})
  - 101 SHR (Q<={SER_IN,Q[W-1:1]})
  - 110 ROTL
  - 111 ROTR
- Single-step ops (HOLD, LOAD, CLEAR): one application regardless of CNT.
- Repeatable ops (INVERT, SHL, SHR, ROTL, ROTR): CNT applications.
- States:
  - IDLE: START=1 at an edge latches OP, D and CNT; rem<=effective count.
    - Effective count is 1 for single-step ops, else CNT.
    - If a repeatable op has CNT=0: go straight to DONE, Q unchanged.
    - Otherwise go to RUN.
  - RUN: BUSY=1. Each edge applies the op once and decrements rem. The application that leaves rem=0 moves to DONE.
  - DONE: DONE=1, BUSY=0 for exactly one cycle, then IDLE. START is ignored in DONE.
- Latency: accept at edge k. Q holds the final value after edge k+n (n = effective count). DONE is high in the cycle after edge k+n.
- START in RUN or DONE: ignored. No queueing; OP/D/CNT changes are ignored until the next accept.
- Q_BAR is written in the same assignment as Q and equals ~Q at all times.
- Shift/rotate boundaries:
  - Bits shifted out are discarded.
  - Rotations with n>=WIDTH wrap naturally (n mod WIDTH net effect).
- Counter: rem is CW bits with no wrap; it is never decremented below 0.

Optional Feature:
- Macro: MULTIMODE_REG_ABORT_EN.
- When defined:
  - Adds input ABORT (1 bit).
  - ABORT=1 at an edge in RUN: no application that edge, Q retains its current partial value, state goes to DONE (one-cycle DONE pulse).
  - Adds output ABORTED (1 bit), high alongside that DONE pulse only.
  - ABORT outside RUN has no effect.
  - Reset values: ABORTED=0.
- When undefined: no ABORT/ABORTED ports; RUN always completes.

Test Plan (WIDTH=8, CW=4):
- Reset: RESETN=0 one edge after arbitrary activity -> Q=8'h00, Q_BAR=8'hFF, BUSY=0, DONE=0. Repeat the reset mid-RUN of ROTL CNT=9 -> no DONE pulse, Q=8'h00.
- LOAD: D=8'hA5, OP=001, CNT=7, START pulse -> one RUN cycle, Q=8'hA5, Q_BAR=8'h5A, DONE high 2 cycles after accept.
- ROTL: from Q=8'h81, OP=110, CNT=3 -> Q sequence 03,06,0C; BUSY high 3 cycles; DONE one cycle. CNT=11 from 8'h81 -> Q=8'h0C.
- SHR: from Q=8'hF0, OP=101, CNT=4, SER_IN=1,0,1,0 per cycle -> Q=8'h5F. INVERT with CNT=0 -> DONE next cycle, Q unchanged, BUSY never high.
- Ignored START: START held high throughout SHL CNT=5 -> exactly one operation, one DONE pulse. A new accept occurs only on the edge after DONE, when back in IDLE.
- ABORT (macro defined): ROTR CNT=8 from Q=8'h01, ABORT at the 3rd RUN edge -> Q=8'h40, DONE=1 and ABORTED=1 for one cycle, then IDLE.
